// File: rtl/rs_syndrome_calc.sv
// RS(255,223) syndrome calculator: 32 Horner accumulators over GF(2^8)
// feed a shadow bank that is streamed out S32 first while the next word loads.
module rs_syndrome_calc #(
    parameter int N    = 255,
    parameter int NSYN = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din_valid,
    input  logic       din_sop,
    input  logic [7:0] din,
    output logic       syn_valid,
    output logic       syn_sop,
    output logic       syn_last,
    output logic [7:0] syn_out,
    output logic       err_flag,
    output logic       sop_err
);

    localparam int IW = $clog2(NSYN);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] alpha_pow(input int j);
        logic [7:0] p;
        p = 8'h01;
        for (int i = 0; i < j; i++) p = xtime(p);
        return p;
    endfunction

    logic [7:0]    acc_q [NSYN];
    logic [7:0]    acc_d [NSYN];
    logic [7:0]    shd_q [NSYN];
    logic [7:0]    shd_d [NSYN];
    logic [7:0]    fb    [NSYN];
    logic [7:0]    cnt_q, cnt_d;
    logic          open_q, open_d;
    logic          act_q, act_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          err_q, err_d;
    logic          serr_q, serr_d;
    logic          accept;
    logic          close;
    logic [7:0]    cur_cnt;
    logic          any_nz;

    // Constant multipliers: each accumulator scales by its own alpha^j.
    for (genvar g = 0; g < NSYN; g++) begin : g_fb
        localparam logic [7:0] AJ = alpha_pow(g + 1);
        assign fb[g] = gf_mul(acc_q[g], AJ);
    end

    always_comb begin
        accept  = din_valid && (din_sop || open_q);
        cur_cnt = din_sop ? 8'd0 : cnt_q;
        close   = accept && (cur_cnt == 8'(N - 1));
        cnt_d   = cnt_q;
        open_d  = open_q;
        if (accept) begin
            open_d = !close;
            cnt_d  = close ? 8'd0 : cur_cnt + 8'd1;
        end
        serr_d = din_valid && din_sop && (cnt_q != 8'd0);
    end

    always_comb begin
        for (int j = 0; j < NSYN; j++) begin
            acc_d[j] = acc_q[j];
            if (accept) acc_d[j] = din_sop ? din : (fb[j] ^ din);
        end
    end

    always_comb begin
        any_nz = 1'b0;
        for (int j = 0; j < NSYN; j++) begin
            shd_d[j] = shd_q[j];
            any_nz   = any_nz | (acc_d[j] != 8'h00);
        end
        err_d = err_q;
        act_d = act_q;
        idx_d = idx_q;
        if (act_q) begin
            if (idx_q == '0) act_d = 1'b0;
            else idx_d = idx_q - 1'b1;
        end
        // Final accumulator values land in the shadow bank on the closing edge.
        if (close) begin
            for (int j = 0; j < NSYN; j++) shd_d[j] = acc_d[j];
            err_d = any_nz;
            act_d = 1'b1;
            idx_d = IW'(NSYN - 1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < NSYN; j++) begin
                acc_q[j] <= 8'h00;
                shd_q[j] <= 8'h00;
            end
            cnt_q  <= 8'd0;
            open_q <= 1'b0;
            act_q  <= 1'b0;
            idx_q  <= '0;
            err_q  <= 1'b0;
            serr_q <= 1'b0;
        end else begin
            for (int j = 0; j < NSYN; j++) begin
                acc_q[j] <= acc_d[j];
                shd_q[j] <= shd_d[j];
            end
            cnt_q  <= cnt_d;
            open_q <= open_d;
            act_q  <= act_d;
            idx_q  <= idx_d;
            err_q  <= err_d;
            serr_q <= serr_d;
        end
    end

    always_comb begin
        syn_valid = act_q;
        syn_sop   = act_q && (idx_q == IW'(NSYN - 1));
        syn_last  = act_q && (idx_q == '0);
        syn_out   = act_q ? shd_q[idx_q] : 8'h00;
        err_flag  = err_q;
        sop_err   = serr_q;
    end

endmodule
